uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter DATA_W, 8, width of one UART character.
REQ-002 Parameter TIMEOUT_CYC, 8192, maximum clk cycles allowed from tx_start to tx_done; range 2..65535.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req0_valid  input  1  requester 0 (MIPS core) has a character pending.
REQ-006 req0_data  input  DATA_W  requester 0 character.
REQ-007 req0_ready  output  1  requester 0 character accepted this cycle.
REQ-008 req1_valid  input  1  requester 1 (debug port) has a character pending.
REQ-009 req1_data  input  DATA_W  requester 1 character.
REQ-010 req1_ready  output  1  requester 1 character accepted this cycle.
REQ-011 tx_start  output  1  one-cycle start pulse to the shared UART transmitter.
REQ-012 tx_data  output  DATA_W  character presented to the transmitter; registered.
REQ-013 tx_done  input  1  one-cycle pulse from the transmitter at the end of the stop bit.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 active_id  output  1  requester owning the transmitter; valid while busy.
REQ-016 timeout_err  output  1  one-cycle pulse when a transfer is aborted by timeout.

Function
REQ-017 The FSM SHALL have three states, IDLE, START and WAIT_DONE, encoded 2'b00, 2'b01, 2'b10; 2'b11 SHALL return to IDLE on the next edge.
REQ-018 In IDLE, requester X is granted when only reqX_valid is high; if both are high, the grant goes to the requester not equal to last_grant.
REQ-019 reqX_ready SHALL be combinational: high only in IDLE for the granted requester; low in every other state and when no valid is high.
REQ-020 On an accept edge (valid and ready), the block SHALL load tx_data with reqX_data, load active_id and last_grant with X, and enter START.
REQ-021 START lasts exactly one cycle with tx_start=1. tx_start SHALL be high in no other state, so it rises one cycle after the accept cycle.
REQ-022 WAIT_DONE: tx_done=1 returns to IDLE on the next edge. The earliest next accept is the cycle after the one in which tx_done was sampled.
REQ-023 tx_done SHALL be ignored in IDLE and START.
REQ-024 A 16-bit timeout counter SHALL clear on entering START and increment in each WAIT_DONE cycle without tx_done.
REQ-025 If the counter equals TIMEOUT_CYC-1 in WAIT_DONE without tx_done, the block SHALL pulse timeout_err for one cycle and return to IDLE. tx_done in that same cycle wins, with no timeout_err.
REQ-026 tx_data and active_id SHALL hold their values until the next accept.
REQ-027 A requester dropping valid while not granted SHALL have no effect; no request is queued inside the block.
REQ-028 Requesters SHALL hold valid and data stable until ready; the block samples data only in the accept cycle.

Reset
REQ-029 Asserting rst SHALL immediately force state=IDLE, tx_start=0, tx_data=0, active_id=0, timeout_err=0, counter=0 and last_grant=1, so requester 0 wins the first tie.
REQ-030 rst asserted mid-transfer SHALL abort without any further tx_start; a pending tx_done after release is ignored because the state is IDLE.
REQ-031 After rst deasserts, the first accept SHALL be possible on the first clk edge.

Structure
REQ-032 Package uart_pkg SHALL hold the state encodings, DATA_W default, TIMEOUT_CYC default and counter width; the block and the Rx/Tx FSMs share it.
REQ-033 Grant selection SHALL be a combinational sub-module rr_arbiter2 (inputs: two valids, last_grant; outputs: grant_valid, grant_id). The FSM, counter and registers stay in uart_tx_arbiter.

Verification
REQ-034 After reset, req0 only with 0x41 -> req0_ready in cycle T, tx_start at T+1, tx_data=0x41; tx_done 10 cycles later -> IDLE, busy=0.
REQ-035 Both valid continuously (0x55 and 0xAA), each tx_done answered -> grants alternate 0,1,0,1 and tx_data alternates 0x55, 0xAA.
REQ-036 TIMEOUT_CYC=16, tx_done withheld -> timeout_err pulse exactly 16 cycles after tx_start, then IDLE and a new grant possible.
REQ-037 tx_done in the same cycle the counter reaches TIMEOUT_CYC-1 -> normal completion, timeout_err stays 0.
REQ-038 rst pulsed during WAIT_DONE, then stray tx_done -> no tx_start, tx_data=0, next tie granted to req0.
REQ-039 tx_done pulsed in IDLE and in START -> ignored; the FSM still waits in WAIT_DONE for a later tx_done.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and default sizing used by the
// Tx arbiter and the Rx/Tx FSMs.
package uart_pkg;

    localparam int DATA_W_DEF      = 8;
    localparam int TIMEOUT_CYC_DEF = 8192;
    localparam int CNT_W           = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_START     = 2'b01,
        ST_WAIT_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant selection; on a tie the requester that did not
// win last time is chosen.
module rr_arbiter2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = valid0 | valid1;
        grant_id    = 1'b0;
        if (valid0 && valid1)
            grant_id = ~last_grant;
        else if (valid1)
            grant_id = 1'b1;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between two character sources (core, debug
// port); holds ownership until tx_done or a watchdog timeout.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_done,
    output logic              busy,
    output logic              active_id,
    output logic              timeout_err
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [DATA_W-1:0] r_tx_data;
    logic              r_active_id;
    logic              r_last_grant;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_grant_valid;
    logic              w_grant_id;
    logic              w_accept;
    logic              w_timeout;

    rr_arbiter2 u_arb (
        .valid0      (req0_valid),
        .valid1      (req1_valid),
        .last_grant  (r_last_grant),
        .grant_valid (w_grant_valid),
        .grant_id    (w_grant_id)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: w_state_nxt = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                // tx_done takes priority over a watchdog expiry in the same cycle
                if (tx_done) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == TMO_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_tx_data    <= '0;
            r_active_id  <= 1'b0;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_tx_data    <= w_grant_id ? req1_data : req0_data;
                r_active_id  <= w_grant_id;
                r_last_grant <= w_grant_id;
                r_cnt        <= '0;
            end else if (r_state == ST_WAIT_DONE && !tx_done) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign req0_ready  = w_accept && !w_grant_id;
    assign req1_ready  = w_accept &&  w_grant_id;
    assign tx_start    = (r_state == ST_START);
    assign tx_data     = r_tx_data;
    assign busy        = (r_state != ST_IDLE);
    assign active_id   = r_active_id;
    assign timeout_err = w_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scenario bench for uart_tx_arbiter: expected characters are queued at accept
// and checked by a monitor whenever tx_start fires.
module tb_uart_tx_arbiter;

    localparam int DW  = 8;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic [DW-1:0] req0_data, req1_data;
    logic          req0_ready, req1_ready;
    logic          tx_start;
    logic [DW-1:0] tx_data;
    logic          tx_done;
    logic          busy, active_id, timeout_err;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic          id;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sb[$];

    uart_tx_arbiter #(.DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_done    (tx_done),
        .busy       (busy),
        .active_id  (active_id),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Every start pulse must match the oldest accepted character.
    always @(negedge clk) begin
        #3;
        if (tx_start === 1'b1) begin
            exp_t e;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_tx_start tx_data=%h (no start expected)", tx_data);
            end else begin
                e = sb.pop_front();
                if (tx_data !== e.data || active_id !== e.id) begin
                    bad++;
                    $display("FAIL tx_start_payload got id=%b data=%h want id=%b data=%h",
                             active_id, tx_data, e.id, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req0_valid = 0; req1_valid = 0; req0_data = 0; req1_data = 0; tx_done = 0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (busy !== 1'b0 || tx_start !== 1'b0 || timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl got busy=%b start=%b tmo=%b want 0 0 0", busy, tx_start, timeout_err);
        end
        total++;
        if (tx_data !== 8'h00 || active_id !== 1'b0) begin
            bad++;
            $display("FAIL reset_data got data=%h id=%b want 00 0", tx_data, active_id);
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        rst = 1'b0; req0_valid = 1; req0_data = 8'h41;
        #1;
        total++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            bad++;
            $display("FAIL single_ready got r0=%b r1=%b want 1 0", req0_ready, req1_ready);
        end
        sb.push_back('{id: 1'b0, data: 8'h41});
        @(negedge clk);
        req0_valid = 0; req0_data = 8'h00;
        #1;
        total++;
        if (tx_start !== 1'b1 || busy !== 1'b1 || req0_ready !== 1'b0) begin
            bad++;
            $display("FAIL single_start got start=%b busy=%b r0=%b want 1 1 0", tx_start, busy, req0_ready);
        end
        repeat (10) @(negedge clk);
        tx_done = 1;
        #1;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL single_wait got busy=%b want 1", busy);
        end
        @(negedge clk);
        tx_done = 0;
        #1;
        total++;
        if (busy !== 1'b0 || tx_data !== 8'h41 || active_id !== 1'b0) begin
            bad++;
            $display("FAIL single_done got busy=%b data=%h id=%b want 0 41 0", busy, tx_data, active_id);
        end
    endtask

    task automatic test_alternate();
        int n;
        logic want_id;
        do_reset();
        @(negedge clk);
        req0_valid = 1; req0_data = 8'h55;
        req1_valid = 1; req1_data = 8'hAA;
        for (int k = 0; k < 4; k++) begin
            want_id = k[0];
            n = 0;
            #1;
            while (!(req0_ready || req1_ready) && n < 20) begin
                @(negedge clk);
                #1;
                n++;
            end
            total++;
            if (n >= 20) begin
                bad++;
                $display("FAIL alt_grant_timeout xfer=%0d no ready within 20 cycles", k);
                break;
            end
            if (req1_ready !== want_id || (req0_ready & req1_ready) !== 1'b0) begin
                bad++;
                $display("FAIL alt_grant xfer=%0d got r0=%b r1=%b want id %b", k, req0_ready, req1_ready, want_id);
            end
            sb.push_back('{id: want_id, data: (want_id ? 8'hAA : 8'h55)});
            @(negedge clk);
            @(negedge clk);
            @(negedge clk);
            tx_done = 1;
            @(negedge clk);
            tx_done = 0;
        end
        req0_valid = 0; req1_valid = 0;
    endtask

    task automatic test_timeout();
        int found = 0;
        do_reset();
        @(negedge clk);
        req0_valid = 1; req0_data = 8'h3C;
        sb.push_back('{id: 1'b0, data: 8'h3C});
        @(negedge clk);
        req0_valid = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            #1;
            if (timeout_err === 1'b1) begin
                found = i;
                break;
            end
        end
        total++;
        if (found != TMO) begin
            bad++;
            $display("FAIL timeout_delay got %0d cycles after tx_start want %0d", found, TMO);
        end
        @(negedge clk);
        #1;
        total++;
        if (timeout_err !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL timeout_after got tmo=%b busy=%b want 0 0", timeout_err, busy);
        end
        req1_valid = 1; req1_data = 8'hC3;
        #1;
        total++;
        if (req1_ready !== 1'b1) begin
            bad++;
            $display("FAIL timeout_regrant got r1=%b want 1", req1_ready);
        end
        sb.push_back('{id: 1'b1, data: 8'hC3});
        @(negedge clk);
        req1_valid = 0;
        @(negedge clk);
        tx_done = 1;
        @(negedge clk);
        tx_done = 0;
    endtask

    task automatic test_done_at_limit();
        int early = 0;
        @(negedge clk);
        req1_valid = 1; req1_data = 8'h7E;
        #1;
        total++;
        if (req1_ready !== 1'b1) begin
            bad++;
            $display("FAIL limit_grant got r1=%b want 1", req1_ready);
        end
        sb.push_back('{id: 1'b1, data: 8'h7E});
        @(negedge clk);
        req1_valid = 0;
        for (int i = 1; i < TMO; i++) begin
            @(negedge clk);
            #1;
            if (timeout_err !== 1'b0 || busy !== 1'b1) early++;
        end
        total++;
        if (early != 0) begin
            bad++;
            $display("FAIL limit_early got %0d bad cycles before limit want 0", early);
        end
        @(negedge clk);
        tx_done = 1;
        #1;
        total++;
        if (timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL limit_done_wins got tmo=%b want 0", timeout_err);
        end
        @(negedge clk);
        tx_done = 0;
        #1;
        total++;
        if (busy !== 1'b0 || timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL limit_idle got busy=%b tmo=%b want 0 0", busy, timeout_err);
        end
    endtask

    task automatic test_reset_mid();
        int starts = 0;
        @(negedge clk);
        req0_valid = 1; req0_data = 8'h99;
        sb.push_back('{id: 1'b0, data: 8'h99});
        @(negedge clk);
        req0_valid = 0;
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || tx_data !== 8'h00 || active_id !== 1'b0) begin
            bad++;
            $display("FAIL midrst_async got busy=%b data=%h id=%b want 0 00 0", busy, tx_data, active_id);
        end
        @(negedge clk);
        rst = 1'b0; tx_done = 1;
        @(negedge clk);
        tx_done = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (tx_start !== 1'b0 || busy !== 1'b0) starts++;
            @(negedge clk);
        end
        total++;
        if (starts != 0) begin
            bad++;
            $display("FAIL midrst_stray_done got %0d active cycles want 0", starts);
        end
        req0_valid = 1; req0_data = 8'h11;
        req1_valid = 1; req1_data = 8'h22;
        #1;
        total++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            bad++;
            $display("FAIL midrst_tie got r0=%b r1=%b want 1 0", req0_ready, req1_ready);
        end
        sb.push_back('{id: 1'b0, data: 8'h11});
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        @(negedge clk);
        tx_done = 1;
        @(negedge clk);
        tx_done = 0;
    endtask

    task automatic test_ignore_done();
        int drops = 0;
        @(negedge clk);
        tx_done = 1;
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL ign_idle got busy=%b want 0", busy);
        end
        @(negedge clk);
        req0_valid = 1; req0_data = 8'h5A;
        sb.push_back('{id: 1'b0, data: 8'h5A});
        @(negedge clk);
        req0_valid = 0;
        @(negedge clk);
        tx_done = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (busy !== 1'b1) drops++;
            @(negedge clk);
        end
        total++;
        if (drops != 0) begin
            bad++;
            $display("FAIL ign_start_done got %0d idle cycles in wait want 0", drops);
        end
        tx_done = 1;
        @(negedge clk);
        tx_done = 0;
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL ign_final_done got busy=%b want 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_timeout();
        test_done_at_limit();
        test_reset_mid();
        test_ignore_done();
        repeat (3) @(negedge clk);
        #4;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got %0d pending starts want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
